// File: rtl/configurable_branch_predictor_pkg.sv
// Shared constants and helpers for the configurable fetch-stage branch predictor.
package configurable_branch_predictor_pkg;

    localparam int unsigned WORD_SIZE    = 16;

    localparam int unsigned BP_NOT_TAKEN = 0;
    localparam int unsigned BP_TAKEN     = 1;
    localparam int unsigned BP_BIMODAL   = 2;
    localparam int unsigned BP_GSHARE    = 3;

    localparam logic [1:0] BHT_WEAK_TAKEN = 2'b10;

    // Next value of a 2-bit saturating direction counter.
    function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'(1);
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'(1);
    endfunction

endpackage

// File: rtl/configurable_branch_predictor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module bp_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/configurable_branch_predictor.sv
// Direct-mapped BTB plus selectable direction predictor with accuracy statistics.
module configurable_branch_predictor
    import configurable_branch_predictor_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = configurable_branch_predictor_pkg::WORD_SIZE,
    parameter int unsigned BTB_IDX_SIZE = 8,
    parameter int unsigned GHR_WIDTH    = 8,
    parameter int unsigned BP_MODE      = 3,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_SIZE-1:0]  pc,
    output logic                  tag_match,
    output logic                  predict_taken,
    output logic [WORD_SIZE-1:0]  predicted_pc,
    output logic [GHR_WIDTH-1:0]  lookup_ghr,
    input  logic                  btb_wr_en,
    input  logic [WORD_SIZE-1:0]  btb_wr_pc,
    input  logic [WORD_SIZE-1:0]  btb_wr_target,
    input  logic                  resolve_en,
    input  logic [WORD_SIZE-1:0]  resolve_pc,
    input  logic [GHR_WIDTH-1:0]  resolve_ghr,
    input  logic                  resolve_taken,
    input  logic                  resolve_mispredict,
    input  logic                  clear_stats,
    output logic [STAT_WIDTH-1:0] stat_resolved,
    output logic [STAT_WIDTH-1:0] stat_mispredicted
);

    localparam int unsigned ENTRIES = 1 << BTB_IDX_SIZE;
    localparam int unsigned TAG_W   = WORD_SIZE - BTB_IDX_SIZE;

    if (GHR_WIDTH < 1 || GHR_WIDTH > BTB_IDX_SIZE || BP_MODE > BP_GSHARE) begin : g_param_error
        $error("configurable_branch_predictor: illegal GHR_WIDTH or BP_MODE");
    end

    logic [ENTRIES-1:0]    valid;
    logic [TAG_W-1:0]      tags    [ENTRIES];
    logic [WORD_SIZE-1:0]  targets [ENTRIES];
    logic [1:0]            bht     [ENTRIES];
    logic [GHR_WIDTH-1:0]  ghr;
    logic [GHR_WIDTH-1:0]  ghr_next;

    logic [BTB_IDX_SIZE-1:0] idx;
    logic [BTB_IDX_SIZE-1:0] bidx;
    logic [BTB_IDX_SIZE-1:0] wr_idx;
    logic [BTB_IDX_SIZE-1:0] rbidx;
    logic                    unused_ok;

    assign idx    = pc[BTB_IDX_SIZE-1:0];
    assign wr_idx = btb_wr_pc[BTB_IDX_SIZE-1:0];

    // gshare hashes the current history into lookups and the fetch-time history into training.
    assign bidx  = (BP_MODE == BP_GSHARE) ? (idx ^ BTB_IDX_SIZE'(ghr)) : idx;
    assign rbidx = (BP_MODE == BP_GSHARE)
                 ? (resolve_pc[BTB_IDX_SIZE-1:0] ^ BTB_IDX_SIZE'(resolve_ghr))
                 : resolve_pc[BTB_IDX_SIZE-1:0];

    assign unused_ok = &{1'b0, resolve_pc[WORD_SIZE-1:BTB_IDX_SIZE]};

    if (GHR_WIDTH == 1) begin : g_ghr1
        assign ghr_next = resolve_taken;
    end else begin : g_ghrn
        assign ghr_next = {ghr[GHR_WIDTH-2:0], resolve_taken};
    end

    // Zero-latency lookup against the pre-edge table contents.
    always_comb begin
        tag_match     = valid[idx] && (tags[idx] == pc[WORD_SIZE-1:BTB_IDX_SIZE]);
        predict_taken = 1'b0;
        if (BP_MODE == BP_TAKEN)
            predict_taken = tag_match;
        else if (BP_MODE >= BP_BIMODAL)
            predict_taken = tag_match && bht[bidx][1];
        predicted_pc  = predict_taken ? targets[idx] : pc + WORD_SIZE'(1);
        lookup_ghr    = (BP_MODE >= BP_BIMODAL) ? ghr : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            ghr   <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
                bht[i]     <= BHT_WEAK_TAKEN;
            end
        end else begin
            if (btb_wr_en) begin
                valid[wr_idx]   <= 1'b1;
                tags[wr_idx]    <= btb_wr_pc[WORD_SIZE-1:BTB_IDX_SIZE];
                targets[wr_idx] <= btb_wr_target;
            end
            if (resolve_en && (BP_MODE >= BP_BIMODAL))
                bht[rbidx] <= sat2_next(bht[rbidx], resolve_taken);
            if (resolve_en && (BP_MODE == BP_GSHARE))
                ghr <= ghr_next;
        end
    end

    bp_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_resolved (
        .clk   (clk),
        .reset (reset),
        .inc   (resolve_en),
        .clr   (clear_stats),
        .count (stat_resolved)
    );

    bp_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_mispredicted (
        .clk   (clk),
        .reset (reset),
        .inc   (resolve_en && resolve_mispredict),
        .clr   (clear_stats),
        .count (stat_mispredicted)
    );

endmodule

// File: tb/tb_configurable_branch_predictor.sv
// Drives four predictor configurations in lockstep and checks them against a table-level model.
module tb_configurable_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        btb_wr_en;
    logic [15:0] btb_wr_pc, btb_wr_target;
    logic        resolve_en, resolve_taken, resolve_mispredict, clear_stats;
    logic [15:0] resolve_pc;
    logic [7:0]  resolve_ghr;

    logic        tm [3];
    logic        pt [3];
    logic [15:0] ppc [3];
    logic [7:0]  lg [3];
    logic [15:0] sr [3];
    logic [15:0] sm [3];
    logic        tm3, pt3;
    logic [15:0] ppc3;
    logic [3:0]  lg3, sr3, sm3;

    int checks = 0;
    int errors = 0;

    // Reference state: plain arrays and integers.
    bit mvalid [256];
    int mtag [256];
    int mtgt [256];
    int mbht2 [256];
    int mbht3 [256];
    int mghr;
    int mres [4];
    int mmis [4];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        configurable_branch_predictor #(
            .WORD_SIZE(16), .BTB_IDX_SIZE(8), .GHR_WIDTH(8), .BP_MODE(m), .STAT_WIDTH(16)
        ) dut (
            .clk(clk), .reset(reset), .pc(pc),
            .tag_match(tm[m]), .predict_taken(pt[m]), .predicted_pc(ppc[m]), .lookup_ghr(lg[m]),
            .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
            .resolve_en(resolve_en), .resolve_pc(resolve_pc), .resolve_ghr(resolve_ghr),
            .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
            .clear_stats(clear_stats), .stat_resolved(sr[m]), .stat_mispredicted(sm[m])
        );
    end

    configurable_branch_predictor #(
        .WORD_SIZE(16), .BTB_IDX_SIZE(8), .GHR_WIDTH(4), .BP_MODE(3), .STAT_WIDTH(4)
    ) dut_gshare (
        .clk(clk), .reset(reset), .pc(pc),
        .tag_match(tm3), .predict_taken(pt3), .predicted_pc(ppc3), .lookup_ghr(lg3),
        .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
        .resolve_en(resolve_en), .resolve_pc(resolve_pc), .resolve_ghr(resolve_ghr[3:0]),
        .resolve_taken(resolve_taken), .resolve_mispredict(resolve_mispredict),
        .clear_stats(clear_stats), .stat_resolved(sr3), .stat_mispredicted(sm3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int m, output logic [31:0] o_tm, output logic [31:0] o_pt,
                           output logic [31:0] o_ppc, output logic [31:0] o_lg,
                           output logic [31:0] o_sr, output logic [31:0] o_sm);
        if (m < 3) begin
            o_tm = 32'(tm[m]); o_pt = 32'(pt[m]); o_ppc = 32'(ppc[m]);
            o_lg = 32'(lg[m]); o_sr = 32'(sr[m]); o_sm = 32'(sm[m]);
        end else begin
            o_tm = 32'(tm3); o_pt = 32'(pt3); o_ppc = 32'(ppc3);
            o_lg = 32'(lg3); o_sr = 32'(sr3); o_sm = 32'(sm3);
        end
    endtask

    function automatic int model_pred_pc(input int m, input int p);
        int  i   = p % 256;
        bit  hit = mvalid[i] && (mtag[i] == p / 256);
        bit  tk;
        case (m)
            0:       tk = 0;
            1:       tk = hit;
            2:       tk = hit && (mbht2[i] >= 2);
            default: tk = hit && (mbht3[i ^ mghr] >= 2);
        endcase
        return tk ? mtgt[i] : (p + 1) % 65536;
    endfunction

    task automatic check_all();
        logic [31:0] o_tm, o_pt, o_ppc, o_lg, o_sr, o_sm;
        int  p   = int'(pc);
        int  i   = p % 256;
        bit  hit = mvalid[i] && (mtag[i] == p / 256);
        int  epc;
        for (int m = 0; m < 4; m++) begin
            get_obs(m, o_tm, o_pt, o_ppc, o_lg, o_sr, o_sm);
            epc = model_pred_pc(m, p);
            chk($sformatf("m%0d_tag_match pc=%h", m, pc), o_tm, 32'(hit));
            chk($sformatf("m%0d_predicted_pc pc=%h", m, pc), o_ppc, 32'(epc));
            chk($sformatf("m%0d_predict_taken pc=%h", m, pc), o_pt,
                32'(hit && epc == mtgt[i] && model_taken(m, p)));
            chk($sformatf("m%0d_lookup_ghr", m), o_lg, 32'((m == 3) ? mghr : 0));
            chk($sformatf("m%0d_stat_resolved", m), o_sr, 32'(mres[m]));
            chk($sformatf("m%0d_stat_mispredicted", m), o_sm, 32'(mmis[m]));
        end
    endtask

    function automatic bit model_taken(input int m, input int p);
        int i   = p % 256;
        bit hit = mvalid[i] && (mtag[i] == p / 256);
        case (m)
            0:       return 0;
            1:       return hit;
            2:       return hit && (mbht2[i] >= 2);
            default: return hit && (mbht3[i ^ mghr] >= 2);
        endcase
    endfunction

    function automatic int sat_step(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_update();
        int smax;
        int ri;
        if (reset) begin
            for (int i = 0; i < 256; i++) begin
                mvalid[i] = 0; mtag[i] = 0; mtgt[i] = 0; mbht2[i] = 2; mbht3[i] = 2;
            end
            mghr = 0;
            for (int m = 0; m < 4; m++) begin mres[m] = 0; mmis[m] = 0; end
            return;
        end
        if (btb_wr_en) begin
            mvalid[btb_wr_pc % 256] = 1;
            mtag[btb_wr_pc % 256]   = int'(btb_wr_pc) / 256;
            mtgt[btb_wr_pc % 256]   = int'(btb_wr_target);
        end
        if (resolve_en) begin
            ri = int'(resolve_pc) % 256;
            mbht2[ri] = sat_step(mbht2[ri], resolve_taken);
            ri = ri ^ (int'(resolve_ghr) % 16);
            mbht3[ri] = sat_step(mbht3[ri], resolve_taken);
            mghr = (mghr * 2 + int'(resolve_taken)) % 16;
        end
        for (int m = 0; m < 4; m++) begin
            smax = (m == 3) ? 15 : 65535;
            if (clear_stats) begin
                mres[m] = 0; mmis[m] = 0;
            end else if (resolve_en) begin
                if (mres[m] < smax) mres[m]++;
                if (resolve_mispredict && mmis[m] < smax) mmis[m]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!reset) check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset = 0; btb_wr_en = 0; resolve_en = 0; resolve_taken = 0;
        resolve_mispredict = 0; clear_stats = 0;
    endtask

    task automatic resolve(input logic [15:0] rpc, input bit taken, input bit mis);
        resolve_en = 1; resolve_pc = rpc; resolve_taken = taken;
        resolve_mispredict = mis; resolve_ghr = 8'(mghr);
        tick();
        idle();
    endtask

    initial begin
        idle();
        pc = 16'h0040; btb_wr_pc = '0; btb_wr_target = '0; resolve_pc = '0; resolve_ghr = '0;
        reset = 1;
        tick(); tick();
        idle();

        // Post-reset lookup
        pc = 16'h0040; #1;
        chk("reset_tag_match", 32'(tm[1]), 32'd0);
        chk("reset_predicted_pc", 32'(ppc[2]), 32'h0041);
        chk("reset_stats", 32'(sr[1]), 32'd0);
        tick();

        // Install and hit / tag-miss
        btb_wr_en = 1; btb_wr_pc = 16'h0040; btb_wr_target = 16'h0100;
        tick(); idle();
        pc = 16'h0040; #1;
        chk("taken_hit_ppc", 32'(ppc[1]), 32'h0100);
        chk("taken_hit_tm", 32'(tm[1]), 32'd1);
        tick();
        pc = 16'h0140; #1;
        chk("taken_tagmiss_ppc", 32'(ppc[1]), 32'h0141);
        tick();

        // Bimodal training down then back up
        pc = 16'h0040;
        repeat (3) resolve(16'h0040, 0, 1);
        #1 chk("bimodal_nt_ppc", 32'(ppc[2]), 32'h0041);
        repeat (2) resolve(16'h0040, 1, 1);
        #1 chk("bimodal_t_ppc", 32'(ppc[2]), 32'h0100);

        // gshare history T,T,N,T, then training with stale history
        pc = 16'h0003;
        resolve(16'h0003, 1, 0);
        resolve(16'h0003, 1, 0);
        resolve(16'h0003, 0, 1);
        resolve(16'h0003, 1, 0);
        #1 chk("gshare_ghr", 32'(lg3), 32'hD);
        resolve_en = 1; resolve_pc = 16'h0003; resolve_taken = 0; resolve_ghr = 8'h00;
        tick(); idle();

        // Same-cycle write and lookup sees old target
        pc = 16'h0040; btb_wr_en = 1; btb_wr_pc = 16'h0040; btb_wr_target = 16'h0200; #1;
        chk("same_cycle_old_ppc", 32'(ppc[1]), 32'h0100);
        tick(); idle(); #1;
        chk("next_cycle_new_ppc", 32'(ppc[1]), 32'h0200);
        pc = 16'hFFFF; #1;
        chk("wrap_ppc", 32'(ppc[1]), 32'h0000);
        tick();

        // Statistics saturation and clear priority
        repeat (20) resolve(16'h0010, 1, 1);
        #1 chk("stat_sat_resolved", 32'(sr3), 32'hF);
        chk("stat_sat_mispredicted", 32'(sm3), 32'hF);
        resolve_en = 1; resolve_mispredict = 1; clear_stats = 1;
        tick(); idle(); #1;
        chk("stat_clear_resolved", 32'(sr[2]), 32'd0);
        chk("stat_clear_mispredicted", 32'(sm3), 32'd0);

        // Reset beats a coincident BTB write
        reset = 1; btb_wr_en = 1; btb_wr_pc = 16'h0055; btb_wr_target = 16'h0777;
        tick(); idle();
        pc = 16'h0055; #1;
        chk("reset_beats_write", 32'(tm[1]), 32'd0);
        tick();

        // Randomized traffic over a small address set to force hits and aliasing
        for (int n = 0; n < 600; n++) begin
            reset              = ($urandom_range(0, 149) == 0);
            pc                 = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
            btb_wr_en          = ($urandom_range(0, 3) == 0);
            btb_wr_pc          = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
            btb_wr_target      = 16'($urandom);
            resolve_en         = ($urandom_range(0, 1) == 0);
            resolve_pc         = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
            resolve_taken      = 1'($urandom);
            resolve_mispredict = 1'($urandom);
            resolve_ghr        = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(mghr);
            clear_stats        = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/configurable_branch_predictor.md
Name: configurable_branch_predictor

Overview:
Next-generation fetch-stage branch predictor. A direct-mapped BTB with valid bits feeds a selectable direction predictor: not-taken, always-taken, bimodal 2-bit, or gshare with a resolution-updated global history. It sits beside the PC register: IF looks up combinationally, ID installs targets, and EX/ID resolution trains the tables. Built-in saturating statistics counters report predictor accuracy.

Parameters:
WORD_SIZE, 16, PC/target width (from constants.v)
BTB_IDX_SIZE, 8, log2 of BTB and BHT entry count
GHR_WIDTH, 8, global history bits; legal range 1..BTB_IDX_SIZE
BP_MODE, 3, 0 = not-taken, 1 = always-taken, 2 = bimodal, 3 = gshare
STAT_WIDTH, 16, width of each statistics counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears all state
pc  in  WORD_SIZE  PC being fetched this cycle
tag_match  out  1  BTB entry at pc index valid and tag equal
predict_taken  out  1  direction prediction
predicted_pc  out  WORD_SIZE  next fetch PC
lookup_ghr  out  GHR_WIDTH  GHR value used for this lookup; pipeline carries it to resolve_ghr
btb_wr_en  in  1  install or overwrite a BTB entry (ID stage, target known)
btb_wr_pc  in  WORD_SIZE  PC of the branch or jump being installed
btb_wr_target  in  WORD_SIZE  its target
resolve_en  in  1  a conditional branch resolved this cycle
resolve_pc  in  WORD_SIZE  PC of the resolved branch
resolve_ghr  in  GHR_WIDTH  lookup_ghr captured when the branch was fetched
resolve_taken  in  1  actual direction
resolve_mispredict  in  1  predicted next PC differed from actual next PC
clear_stats  in  1  zero both statistics counters
stat_resolved  out  STAT_WIDTH  count of resolve_en pulses
stat_mispredicted  out  STAT_WIDTH  count of resolve_en && resolve_mispredict

Behaviour:
- Address split: idx = pc[BTB_IDX_SIZE-1:0]; tag = pc[WORD_SIZE-1:BTB_IDX_SIZE]. BTB entry = {valid, tag, target[WORD_SIZE-1:0]}, storing the full target.
- BHT index: idx for mode 2; idx XOR zero-extended GHR for mode 3 (lookup uses current ghr, training uses resolve_ghr).
- Lookup is purely combinational, with zero-cycle latency. tag_match = valid[idx] && tag equal.
- predict_taken: mode 0 gives 0; mode 1 gives tag_match; modes 2/3 give tag_match && bht[bidx][1].
- predicted_pc = predict_taken ? target[idx] : pc+1, computed modulo 2^WORD_SIZE (0xFFFF+1 = 0x0000).
- lookup_ghr = ghr in modes 3 and 2 alike; it is don't-care in modes 0/1 and drives 0 there.
- BTB write: on btb_wr_en, at the clock edge, set valid, tag and target at the btb_wr_pc index. A collision overwrites silently. The BHT is not touched.
- Training (modes 2/3 only), when resolve_en is high:
  - The 2-bit counter saturates: taken increments toward 2'b11, not-taken decrements toward 2'b00.
  - Mode 3 also shifts history: ghr <= {ghr[GHR_WIDTH-2:0], resolve_taken}. For GHR_WIDTH = 1, ghr <= resolve_taken.
  - Modes 0/1 update only the statistics.
- Statistics counters saturate at all-ones and never wrap. clear_stats takes priority over an increment in the same cycle, and the result is 0.
- Reset values: all valid = 0, all BHT = 2'b10 (weakly taken), ghr = 0, targets/tags = 0, stats = 0. Consequently tag_match = 0, predict_taken = 0, predicted_pc = pc+1 and lookup_ghr = 0 on the cycle after reset.
- Reset mid-operation: coincident writes and resolves are discarded, and reset wins over everything.
- Same-cycle events:
  - Write and lookup to the same index: the lookup sees the old contents (no bypass).
  - Resolve and lookup to the same BHT entry: the lookup sees the old counter and old ghr.
  - Write and resolve in the same cycle: both take effect, since they touch disjoint state.
- Illegal parameters (GHR_WIDTH > BTB_IDX_SIZE, BP_MODE > 3) stop elaboration via a generate-time error.

Decomposition:
- constants.v gains BP_NOT_TAKEN/BP_TAKEN/BP_BIMODAL/BP_GSHARE mode codes and BHT_WEAK_TAKEN = 2'b10. WORD_SIZE stays there.
- One sub-module, bp_sat_counter (parameter WIDTH; inputs inc, clr; output count; saturating), is instantiated twice for the statistics.
- The BTB and BHT arrays stay inline.

Test Plan:
- Reset, then pc = 0x0040 → tag_match = 0, predict_taken = 0, predicted_pc = 0x0041. Stats read 0.
- Mode 1: write pc 0x0040 → target 0x0100, then look up 0x0040 → tag_match = 1, predicted_pc = 0x0100. Look up 0x0140 (same idx, tag differs) → tag_match = 0, predicted_pc = 0x0141.
- Mode 2: install 0x0040, then three not-taken resolves → counter 10→01→00→00 and predicted_pc = 0x0041. Two taken resolves → 01→10, and predicted_pc = 0x0100 again.
- Mode 3, GHR_WIDTH = 4: resolves T,T,N,T → ghr = 4'b1101. A lookup at 0x0003 trains/reads BHT[0x03^0x0D = 0x0E]. A resolve carrying the stale resolve_ghr = 0 trains BHT[0x03].
- Same-cycle write and lookup at 0x0040 with new target 0x0200 → this cycle predicted_pc = old value, next cycle = 0x0200. pc = 0xFFFF with a BTB miss → predicted_pc = 0x0000.
- STAT_WIDTH = 4: 20 mispredicted resolves → both stats stick at 0xF. clear_stats together with resolve_en → both 0. Reset asserted during a btb_wr_en → entry stays invalid.
